// File: rtl/mem_seq_ctrl.sv
// Load/store sequencer between the execute stage and a single-port data memory.
// Issues one access at a time, stalls the pipeline while it is outstanding, and flags timeouts/illegal ops.
module mem_seq_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic              mem_RE,
    input  logic              mem_WE,
    input  logic              flush,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] count;
    logic       start;
    logic       illegal;
    logic       timeout_hit;

    assign start       = op_valid & ~flush & (mem_RE ^ mem_WE);
    assign illegal     = op_valid & ~flush & mem_RE & mem_WE;
    assign timeout_hit = (count == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        mem_req     = 1'b0;
        stall       = 1'b0;
        rdata_valid = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = REQ;
                    stall      = 1'b1;
                end else if (illegal) begin
                    state_next = ERR;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                // An ack on the final allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    state_next = DONE;
                end else if (timeout_hit) begin
                    state_next = ERR;
                end
            end
            DONE: begin
                rdata_valid = ~mem_wr;
                state_next  = IDLE;
            end
            ERR: begin
                err        = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Access attributes are frozen at issue so they stay stable for the whole request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr    <= 1'b0;
            rdata     <= '0;
        end else begin
            if (state == IDLE && start) begin
                mem_addr  <= addr;
                mem_wdata <= wdata;
                mem_wr    <= mem_WE;
                count     <= '0;
            end
            if (state == REQ) begin
                if (mem_ack) begin
                    if (!mem_wr) begin
                        rdata <= mem_rdata;
                    end
                end else begin
                    count <= count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Randomised scoreboard bench for mem_seq_ctrl: a transaction-level model predicts request,
// stall, load-data and error events; a monitor and a memory responder consume them independently.
module tb_mem_seq_ctrl;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
    localparam int NOACK   = 1000;

    localparam int K_LOAD    = 0;
    localparam int K_STORE   = 1;
    localparam int K_ILLEGAL = 2;
    localparam int K_FLUSH   = 3;
    localparam int K_NONE    = 4;

    localparam int OUT_STORE   = 0;
    localparam int OUT_LOAD    = 1;
    localparam int OUT_TIMEOUT = 2;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [DATA_W-1:0] wdata;
        int                len;
        int                outcome;
    } req_exp_t;

    typedef struct {
        int                delay;
        logic [DATA_W-1:0] data;
    } resp_t;

    logic              clk;
    logic              rst_n;
    logic              op_valid;
    logic              mem_RE;
    logic              mem_WE;
    logic              flush;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              stall;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              err;

    mem_seq_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .mem_RE     (mem_RE),
        .mem_WE     (mem_WE),
        .flush      (flush),
        .addr       (addr),
        .wdata      (wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .stall      (stall),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    req_exp_t          q_req[$];
    int                q_stall[$];
    logic [DATA_W-1:0] q_rdata[$];
    bit                q_err[$];
    resp_t             q_resp[$];

    bit                mon_en      = 1'b0;
    bit                resp_en     = 1'b0;
    logic              force_ack   = 1'b0;
    logic [DATA_W-1:0] force_rdata = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_noise(input bit idle);
        op_valid = idle ? 1'b0 : 1'($urandom);
        mem_RE   = 1'($urandom);
        mem_WE   = 1'($urandom);
        flush    = 1'($urandom);
        addr     = 16'($urandom);
        wdata    = $urandom;
    endtask

    // Transaction-level model: predicts every observable event from the op kind and ack delay.
    task automatic applyStimulus(input int kind, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                                 input int delay, input logic [DATA_W-1:0] rd, input int gap);
        int       len;
        int       wait_cycles;
        req_exp_t e;
        resp_t    r;
        op_valid    = 1'b1;
        addr        = a;
        wdata       = wd;
        flush       = 1'b0;
        mem_RE      = 1'b0;
        mem_WE      = 1'b0;
        wait_cycles = 0;
        case (kind)
            K_LOAD:    mem_RE = 1'b1;
            K_STORE:   mem_WE = 1'b1;
            K_ILLEGAL: begin
                mem_RE = 1'b1;
                mem_WE = 1'b1;
            end
            K_FLUSH: begin
                flush  = 1'b1;
                mem_RE = 1'b1;
                mem_WE = 1'($urandom);
            end
            default: flush = 1'($urandom);
        endcase
        if (kind == K_LOAD || kind == K_STORE) begin
            len       = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
            e.addr    = a;
            e.wr      = (kind == K_STORE);
            e.wdata   = wd;
            e.len     = len;
            e.outcome = (delay >= TIMEOUT) ? OUT_TIMEOUT : (kind == K_LOAD) ? OUT_LOAD : OUT_STORE;
            q_req.push_back(e);
            q_stall.push_back(len + 1);
            r.delay = delay;
            r.data  = rd;
            q_resp.push_back(r);
            if (e.outcome == OUT_LOAD) q_rdata.push_back(rd);
            if (e.outcome == OUT_TIMEOUT) q_err.push_back(1'b1);
            wait_cycles = len + 1;
        end else if (kind == K_ILLEGAL) begin
            q_err.push_back(1'b1);
            wait_cycles = 1;
        end
        next_cycle();
        repeat (wait_cycles) begin
            drive_noise(1'b0);
            next_cycle();
        end
        repeat (gap) begin
            drive_noise(1'b1);
            next_cycle();
        end
    endtask

    // Memory responder: acks each request after the delay the stimulus chose, and sprinkles stray acks otherwise.
    int    r_cnt    = 0;
    bit    r_active = 1'b0;
    resp_t r_cur;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        r_cur.delay = NOACK;
        r_cur.data  = '0;
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                r_active  = 1'b0;
                mem_ack   = force_ack;
                mem_rdata = force_rdata;
            end else if (mem_req) begin
                if (!r_active) begin
                    r_active = 1'b1;
                    r_cnt    = 0;
                    if (q_resp.size() > 0) begin
                        r_cur = q_resp.pop_front();
                    end else begin
                        r_cur.delay = NOACK;
                        r_cur.data  = '0;
                    end
                end else begin
                    r_cnt++;
                end
                mem_ack   = (r_cnt == r_cur.delay);
                mem_rdata = mem_ack ? r_cur.data : $urandom;
            end else begin
                r_active  = 1'b0;
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    int                stall_run  = 0;
    int                req_run    = 0;
    bit                req_active = 1'b0;
    req_exp_t          cur;
    logic [DATA_W-1:0] hold       = '0;
    int                exp_len;

    always @(negedge clk) begin
        if (!mon_en) begin
            stall_run  = 0;
            req_run    = 0;
            req_active = 1'b0;
            hold       = '0;
        end else begin
            if (stall) begin
                stall_run++;
            end else if (stall_run > 0) begin
                checkOutput("stall_expected", 64'(q_stall.size() > 0), 64'd1);
                if (q_stall.size() > 0) begin
                    exp_len = q_stall.pop_front();
                    checkOutput("stall_len", 64'(stall_run), 64'(exp_len));
                end
                stall_run = 0;
            end

            if (mem_req) begin
                if (!req_active) begin
                    checkOutput("req_expected", 64'(q_req.size() > 0), 64'd1);
                    if (q_req.size() > 0) begin
                        cur = q_req.pop_front();
                    end else begin
                        cur.addr    = '0;
                        cur.wr      = 1'b0;
                        cur.wdata   = '0;
                        cur.len     = 0;
                        cur.outcome = OUT_STORE;
                    end
                    req_active = 1'b1;
                    req_run    = 0;
                end
                req_run++;
                checkOutput("mem_addr", 64'(mem_addr), 64'(cur.addr));
                checkOutput("mem_wr", 64'(mem_wr), 64'(cur.wr));
                checkOutput("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
            end else if (req_active) begin
                // The cycle right after the request must carry the completion pulse.
                checkOutput("req_len", 64'(req_run), 64'(cur.len));
                checkOutput("rdv_at_end", 64'(rdata_valid), 64'(cur.outcome == OUT_LOAD));
                checkOutput("err_at_end", 64'(err), 64'(cur.outcome == OUT_TIMEOUT));
                req_active = 1'b0;
            end

            if (rdata_valid) begin
                checkOutput("rdv_expected", 64'(q_rdata.size() > 0), 64'd1);
                if (q_rdata.size() > 0) hold = q_rdata.pop_front();
                checkOutput("rdata", 64'(rdata), 64'(hold));
            end else begin
                checkOutput("rdata_hold", 64'(rdata), 64'(hold));
            end

            if (err) begin
                checkOutput("err_expected", 64'(q_err.size() > 0), 64'd1);
                if (q_err.size() > 0) void'(q_err.pop_front());
            end
        end
    end

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_mem_req"}, 64'(mem_req), 64'd0);
        checkOutput({tag, "_mem_wr"}, 64'(mem_wr), 64'd0);
        checkOutput({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        checkOutput({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        checkOutput({tag, "_rdata"}, 64'(rdata), 64'd0);
        checkOutput({tag, "_rdata_valid"}, 64'(rdata_valid), 64'd0);
        checkOutput({tag, "_err"}, 64'(err), 64'd0);
        checkOutput({tag, "_stall"}, 64'(stall), 64'd0);
    endtask

    task automatic run_random(input int count);
        int sel;
        int kind;
        int dsel;
        int delay;
        for (int i = 0; i < count; i++) begin
            sel  = $urandom_range(0, 9);
            kind = (sel < 4) ? K_LOAD : (sel < 7) ? K_STORE : (sel == 7) ? K_ILLEGAL :
                   (sel == 8) ? K_FLUSH : K_NONE;
            dsel = $urandom_range(0, 9);
            if (dsel < 6)       delay = $urandom_range(0, 3);
            else if (dsel == 6) delay = TIMEOUT - 1;
            else if (dsel == 7) delay = NOACK;
            else                delay = $urandom_range(4, 8);
            applyStimulus(kind, 16'($urandom), $urandom, delay, $urandom, $urandom_range(0, 2));
        end
    endtask

    task automatic check_drained(input string tag);
        checkOutput({tag, "_q_req"}, 64'(q_req.size()), 64'd0);
        checkOutput({tag, "_q_stall"}, 64'(q_stall.size()), 64'd0);
        checkOutput({tag, "_q_rdata"}, 64'(q_rdata.size()), 64'd0);
        checkOutput({tag, "_q_err"}, 64'(q_err.size()), 64'd0);
        checkOutput({tag, "_q_resp"}, 64'(q_resp.size()), 64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        op_valid = 1'b0;
        mem_RE   = 1'b0;
        mem_WE   = 1'b0;
        flush    = 1'b0;
        addr     = '0;
        wdata    = '0;
        repeat (3) next_cycle();
        settle();
        check_reset_values("reset");
        rst_n   = 1'b1;
        resp_en = 1'b1;
        mon_en  = 1'b1;
        next_cycle();

        $display("[TB] directed transactions");
        applyStimulus(K_LOAD, 16'h0040, 32'h0000_0000, 2, 32'hDEAD_BEEF, 1);
        applyStimulus(K_STORE, 16'h0010, 32'h1234_5678, 0, 32'hCAFE_F00D, 1);
        applyStimulus(K_LOAD, 16'h0100, 32'h0BAD_0001, NOACK, 32'h5555_AAAA, 1);
        applyStimulus(K_LOAD, 16'h0200, 32'h0000_0002, TIMEOUT - 1, 32'hA5A5_0F0F, 0);
        applyStimulus(K_ILLEGAL, 16'h0300, 32'h0000_0003, 0, 32'h0, 1);
        applyStimulus(K_FLUSH, 16'h0400, 32'h0000_0004, 0, 32'h0, 1);
        applyStimulus(K_LOAD, 16'h0500, 32'h0000_0005, 0, 32'h1111_2222, 0);
        applyStimulus(K_LOAD, 16'h0504, 32'h0000_0006, 1, 32'h3333_4444, 0);
        applyStimulus(K_STORE, 16'h0508, 32'h7777_8888, 3, 32'h0, 2);

        $display("[TB] random transactions");
        run_random(40);
        repeat (3) begin
            drive_noise(1'b1);
            next_cycle();
        end
        check_drained("phase1");

        $display("[TB] reset during request");
        mon_en    = 1'b0;
        resp_en   = 1'b0;
        force_ack = 1'b0;
        drive_noise(1'b1);
        next_cycle();
        op_valid = 1'b1;
        mem_RE   = 1'b1;
        mem_WE   = 1'b0;
        flush    = 1'b0;
        addr     = 16'h0ABC;
        wdata    = 32'h0102_0304;
        settle();
        checkOutput("rst_start_stall", 64'(stall), 64'd1);
        next_cycle();
        drive_noise(1'b1);
        settle();
        checkOutput("rst_req1", 64'(mem_req), 64'd1);
        checkOutput("rst_req1_addr", 64'(mem_addr), 64'h0ABC);
        next_cycle();
        rst_n = 1'b0;
        settle();
        checkOutput("rst_req2", 64'(mem_req), 64'd1);
        next_cycle();
        force_ack   = 1'b1;
        force_rdata = 32'hBAD0_BAD0;
        settle();
        check_reset_values("rst_mid");
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checkOutput("late_ack_req", 64'(mem_req), 64'd0);
            checkOutput("late_ack_rdv", 64'(rdata_valid), 64'd0);
            checkOutput("late_ack_rdata", 64'(rdata), 64'd0);
            checkOutput("late_ack_err", 64'(err), 64'd0);
            next_cycle();
        end
        force_ack = 1'b0;
        next_cycle();
        resp_en = 1'b1;
        mon_en  = 1'b1;
        next_cycle();

        $display("[TB] recovery after reset");
        applyStimulus(K_LOAD, 16'h0ABC, 32'h0, 1, 32'h600D_600D, 0);
        run_random(12);
        applyStimulus(K_STORE, 16'h00FF, 32'hFEED_BEEF, 2, 32'h0, 1);
        repeat (3) begin
            drive_noise(1'b1);
            next_cycle();
        end
        check_drained("final");
        checkOutput("final_stall_idle", 64'(stall_run), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_seq_ctrl.md
MEM_SEQ_CTRL -- requirements
Module: mem_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16: data-memory address width.
REQ-002 Parameter DATA_W, default 32: data word width.
REQ-003 Parameter TIMEOUT, default 16: maximum REQ-state cycles without mem_ack before an error is raised; legal range 2..255.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous reset, active-low.
REQ-006 op_valid  in  1  execute stage holds a valid instruction.
REQ-007 mem_RE  in  1  decoded load (opcode 1100).
REQ-008 mem_WE  in  1  decoded store (opcode 1101).
REQ-009 flush  in  1  branch taken; the instruction currently presented is squashed.
REQ-010 addr  in  ADDR_W  effective address from ALU.
REQ-011 wdata  in  DATA_W  store data.
REQ-012 mem_ack  in  1  memory completes the outstanding access; mem_rdata valid in the same cycle.
REQ-013 mem_rdata  in  DATA_W  load data.
REQ-014 mem_req  out  1  access request to memory.
REQ-015 mem_wr  out  1  1 = write, 0 = read; meaningful only while mem_req=1.
REQ-016 mem_addr  out  ADDR_W  registered address.
REQ-017 mem_wdata  out  DATA_W  registered store data.
REQ-018 stall  out  1  freezes the fetch/decode/execute pipeline registers.
REQ-019 rdata  out  DATA_W  load result for write-back.
REQ-020 rdata_valid  out  1  one-cycle pulse: rdata holds the load result.
REQ-021 err  out  1  one-cycle pulse: timeout or illegal op.

Function
REQ-022 The FSM SHALL have four states: IDLE, REQ, DONE, ERR.
REQ-023 start = op_valid & ~flush & (mem_RE ^ mem_WE), evaluated only in IDLE.
REQ-024 In IDLE with start=1, the block SHALL capture addr, wdata and mem_WE into mem_addr, mem_wdata and mem_wr, clear the timeout counter, and enter REQ.
REQ-025 In IDLE with op_valid & ~flush & mem_RE & mem_WE, the block SHALL issue no access, enter ERR, and not assert stall.
REQ-026 stall SHALL be combinational: (state==IDLE & start) | state==REQ; stall=0 in DONE and ERR.
REQ-027 mem_req SHALL be 1 exactly while in REQ; mem_addr, mem_wdata and mem_wr SHALL hold stable throughout REQ.
REQ-028 In REQ with mem_ack=1, the block SHALL enter DONE; for reads, mem_rdata is registered into rdata on that edge.
REQ-029 In REQ with mem_ack=0, the counter SHALL increment; when counter reaches TIMEOUT-1 without ack, the next state SHALL be ERR.
REQ-030 DONE SHALL last one cycle: rdata_valid=1 iff mem_wr=0; then go to IDLE, ignoring op_valid during DONE.
REQ-031 ERR SHALL last one cycle with err=1, mem_req=0, rdata_valid=0; then go to IDLE.
REQ-032 Minimum latency: start in cycle 0, mem_req in cycle 1, ack in cycle 1 -> rdata_valid in cycle 2; stall high in cycles 0-1.
REQ-033 flush SHALL be ignored outside IDLE; an issued access always completes or times out.
REQ-034 mem_ack outside REQ SHALL be ignored.
REQ-035 rdata SHALL hold its last value until the next successful load.

Reset
REQ-036 While rst_n=0 at a rising edge: state=IDLE, counter=0, mem_addr=0, mem_wdata=0, mem_wr=0, rdata=0; mem_req, rdata_valid and err are then 0, and stall is 0 unless start is decoded.
REQ-037 Reset asserted in REQ SHALL abandon the access: mem_req=0 the cycle after the reset edge; a late mem_ack SHALL be ignored.

Verification
REQ-038 Load: mem_RE=1, addr=0x0040, ack in cycle 3 with mem_rdata=0xDEADBEEF -> mem_req cycles 1-3, stall cycles 0-3, rdata_valid with rdata=0xDEADBEEF in cycle 4.
REQ-039 Store: mem_WE=1, addr=0x0010, wdata=0x12345678, ack in first REQ cycle -> mem_wr=1, one mem_req cycle, no rdata_valid, stall low in DONE.
REQ-040 Timeout: TIMEOUT=16, no ack -> mem_req high exactly 16 cycles, err pulse in the next cycle, then IDLE.
REQ-041 Illegal/flush: mem_RE=mem_WE=1 -> err pulse, no mem_req; mem_RE=1 with flush=1 -> no request, no stall.
REQ-042 Back-to-back loads: a new load presented the cycle after DONE -> mem_req again one cycle later; no double issue during DONE.
REQ-043 Reset mid-REQ: rst_n=0 in REQ cycle 2, then ack asserted -> all outputs at reset values, no rdata_valid.
